// File: rtl/kb_event_ctrl.sv
// kb_event_ctrl
//   Turns the raw PS/2 set-2 byte stream into whole key-press events.
//   E0 / F0 / E1 prefixes are decoded, shift and caps-lock state is
//   tracked, and make events are buffered in a first-word-fall-through
//   FIFO with a valid/ready handshake toward the editor core.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | waiting for a code or prefix
//   EXT     | E0 seen, next code is an extended make
//   BRK     | F0 seen, next code is a break
//   EXT_BRK | E0 F0 seen, next code is an extended break
//   SKIP    | inside the E1 pause sequence, bytes are swallowed
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   scan_code       byte from keyboard interface
//   scan_code_ready one-cycle strobe, scan_code valid
//   evt_code        make code of head event
//   evt_ext         head event was E0-prefixed
//   evt_upper       head event case flag (shift_held ^ caps_lock at capture)
//   evt_valid       FIFO non-empty
//   evt_ready       consumer accepts head (pop on evt_valid && evt_ready)
//   shift_held      left or right shift currently down
//   caps_lock       caps-lock toggle state
//   overflow        sticky, an event was dropped on a full FIFO
//   fifo_count      FIFO occupancy

module kb_event_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        scan_code,
    input  logic              scan_code_ready,
    output logic [7:0]        evt_code,
    output logic              evt_ext,
    output logic              evt_upper,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic              shift_held,
    output logic              caps_lock,
    output logic              overflow,
    output logic [ADDR_W:0]   fifo_count
);

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_PAUSE  = 8'hE1;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    // E1 is followed by seven more bytes of the pause sequence
    localparam logic [2:0] PAUSE_LEN   = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } state_t;

    state_t          state;
    logic [2:0]      skip_cnt;
    logic            shift_l;
    logic            shift_r;
    logic            caps_down;

    // FIFO entry layout: {code, ext, upper}
    logic [9:0]      mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic            is_discard;
    logic            push;
    logic            push_ext;
    logic            upper_now;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic [ADDR_W:0] count_nxt;

    assign shift_held = shift_l | shift_r;
    // Case flag uses the flag values before this byte updates them
    assign upper_now  = shift_held ^ caps_lock;

    always_comb begin
        is_discard = 1'b0;
        case (scan_code)
            8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE: is_discard = 1'b1;
            default:                           is_discard = 1'b0;
        endcase
    end

    // Event generation is decoded combinationally so the FIFO write lands
    // on the same edge that consumes the byte.
    always_comb begin
        push     = 1'b0;
        push_ext = 1'b0;
        if (scan_code_ready && !is_discard) begin
            case (state)
                IDLE: begin
                    if (scan_code != CODE_EXT    && scan_code != CODE_BRK    &&
                        scan_code != CODE_PAUSE  && scan_code != CODE_LSHIFT &&
                        scan_code != CODE_RSHIFT && scan_code != CODE_CAPS)
                        push = 1'b1;
                end
                EXT: begin
                    // E0 12 / E0 59 are fake shifts emitted around nav keys
                    if (scan_code != CODE_BRK    && scan_code != CODE_EXT &&
                        scan_code != CODE_LSHIFT && scan_code != CODE_RSHIFT) begin
                        push     = 1'b1;
                        push_ext = 1'b1;
                    end
                end
                default: begin
                    push     = 1'b0;
                    push_ext = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            skip_cnt  <= '0;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_lock <= 1'b0;
            caps_down <= 1'b0;
        end else if (scan_code_ready) begin
            if (state == SKIP) begin
                skip_cnt <= skip_cnt - 3'd1;
                if (skip_cnt == 3'd1)
                    state <= IDLE;
            end else if (is_discard) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        case (scan_code)
                            CODE_EXT:    state <= EXT;
                            CODE_BRK:    state <= BRK;
                            CODE_PAUSE: begin
                                state    <= SKIP;
                                skip_cnt <= PAUSE_LEN;
                            end
                            CODE_LSHIFT: shift_l <= 1'b1;
                            CODE_RSHIFT: shift_r <= 1'b1;
                            CODE_CAPS: begin
                                // caps_down blocks typematic repeats from re-toggling
                                if (!caps_down) begin
                                    caps_lock <= ~caps_lock;
                                    caps_down <= 1'b1;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                    EXT: begin
                        if (scan_code == CODE_BRK)
                            state <= EXT_BRK;
                        else if (scan_code != CODE_EXT)
                            state <= IDLE;
                    end
                    BRK: begin
                        if (scan_code != CODE_BRK) begin
                            state <= IDLE;
                            if (scan_code == CODE_LSHIFT) shift_l   <= 1'b0;
                            if (scan_code == CODE_RSHIFT) shift_r   <= 1'b0;
                            if (scan_code == CODE_CAPS)   caps_down <= 1'b0;
                        end
                    end
                    EXT_BRK: begin
                        if (scan_code != CODE_BRK) begin
                            state <= IDLE;
                            if (scan_code == CODE_CAPS) caps_down <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign pop   = evt_valid && evt_ready;
    assign full  = (fifo_count == (ADDR_W+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push needs
    assign wr_en = push && (!full || pop);

    always_comb begin
        count_nxt = fifo_count + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            evt_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {scan_code, push_ext, upper_now};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop)
                overflow <= 1'b1;
            fifo_count <= count_nxt;
            evt_valid  <= (count_nxt != '0);
        end
    end

    assign evt_code  = mem[rd_ptr][9:2];
    assign evt_ext   = mem[rd_ptr][1];
    assign evt_upper = mem[rd_ptr][0];

endmodule

// File: tb/tb_kb_event_ctrl.sv
module tb_kb_event_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_code_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_upper;
    logic       evt_valid;
    logic       evt_ready;
    logic       shift_held;
    logic       caps_lock;
    logic       overflow;
    logic [3:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    kb_event_ctrl #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .scan_code       (scan_code),
        .scan_code_ready (scan_code_ready),
        .evt_code        (evt_code),
        .evt_ext         (evt_ext),
        .evt_upper       (evt_upper),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .shift_held      (shift_held),
        .caps_lock       (caps_lock),
        .overflow        (overflow),
        .fifo_count      (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: prefix flags plus a queue of pending events
    logic [9:0] mq[$];
    logic m_sl, m_sr, m_caps, m_caps_down, m_ext, m_brk, m_ovf;
    int   m_skip;

    task automatic model_reset();
        mq.delete();
        m_sl = 0; m_sr = 0; m_caps = 0; m_caps_down = 0;
        m_ext = 0; m_brk = 0; m_ovf = 0; m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output logic p, output logic [9:0] w);
        logic up;
        p  = 0;
        up = (m_sl | m_sr) ^ m_caps;
        w  = {b, m_ext, up};
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'h00 || b == 8'hFF || b == 8'hAA || b == 8'hFA || b == 8'hFE) begin
            m_ext = 0; m_brk = 0;
        end else if (m_brk) begin
            if (b != 8'hF0) begin
                if (!m_ext && b == 8'h12) m_sl = 0;
                if (!m_ext && b == 8'h59) m_sr = 0;
                if (b == 8'h58) m_caps_down = 0;
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b != 8'hE0) begin
                if (b != 8'h12 && b != 8'h59) p = 1;
                m_ext = 0;
            end
        end else begin
            case (b)
                8'hE0: m_ext = 1;
                8'hF0: m_brk = 1;
                8'hE1: m_skip = 7;
                8'h12: m_sl = 1;
                8'h59: m_sr = 1;
                8'h58: if (!m_caps_down) begin m_caps = ~m_caps; m_caps_down = 1; end
                default: p = 1;
            endcase
        end
    endtask

    task automatic model_cycle(input logic has_byte, input logic [7:0] b, input logic rdy);
        logic p;
        logic [9:0] w;
        logic do_pop;
        p = 0; w = '0;
        do_pop = (mq.size() > 0) && rdy;
        if (has_byte) model_byte(b, p, w);
        if (do_pop) void'(mq.pop_front());
        if (p) begin
            if (mq.size() < 8) mq.push_back(w);
            else m_ovf = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("evt_valid",  32'(evt_valid),  32'(mq.size() > 0));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("shift_held", 32'(shift_held), 32'(m_sl | m_sr));
        chk("caps_lock",  32'(caps_lock),  32'(m_caps));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        if (mq.size() > 0) begin
            chk("evt_code",  32'(evt_code),  32'(mq[0][9:2]));
            chk("evt_ext",   32'(evt_ext),   32'(mq[0][1]));
            chk("evt_upper", 32'(evt_upper), 32'(mq[0][0]));
        end
    endtask

    // All cycle tasks start and end at posedge + 1
    task automatic cycle(input logic has_byte, input logic [7:0] b, input logic rdy);
        scan_code       = b;
        scan_code_ready = has_byte;
        evt_ready       = rdy;
        model_cycle(has_byte, b, rdy);
        @(posedge clk);
        #1;
        scan_code_ready = 0;
        compare_all();
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        cycle(1'b1, b, rdy);
    endtask

    task automatic pop_check(input logic [7:0] code, input logic ext, input logic up);
        chk("head_code",  32'(evt_code),  32'(code));
        chk("head_ext",   32'(evt_ext),   32'(ext));
        chk("head_upper", 32'(evt_upper), 32'(up));
        chk("head_valid", 32'(evt_valid), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        #1;
        model_reset();
        chk("rst_valid", 32'(evt_valid),  32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_code",  32'(evt_code),   32'd0);
        chk("rst_ext",   32'(evt_ext),    32'd0);
        chk("rst_upper", 32'(evt_upper),  32'd0);
        chk("rst_shift", 32'(shift_held), 32'd0);
        chk("rst_caps",  32'(caps_lock),  32'd0);
        chk("rst_ovf",   32'(overflow),   32'd0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] pool [12];
        pool = '{8'h12, 8'h59, 8'h58, 8'hF0, 8'hE0, 8'hE1,
                 8'h1C, 8'h75, 8'hAA, 8'h00, 8'h2B, 8'h6B};
        if ($urandom_range(0, 4) == 0) return 8'($urandom_range(0, 255));
        return pool[$urandom_range(0, 11)];
    endfunction

    initial begin
        logic [7:0] pause_seq [8];
        reset = 1; scan_code = 0; scan_code_ready = 0; evt_ready = 0;
        model_reset();
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        do_reset();

        // Single make, one-cycle latency, then pop
        send(8'h1C, 1'b0);
        chk("t1_valid", 32'(evt_valid), 32'd1);
        pop_check(8'h1C, 1'b0, 1'b0);
        chk("t1_count", 32'(fifo_count), 32'd0);

        // Shift press / release around a key
        send(8'h12, 1'b0);
        chk("t2_shift_on", 32'(shift_held), 32'd1);
        send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h12, 1'b0);
        chk("t2_shift_off", 32'(shift_held), 32'd0);
        send(8'h1C, 1'b0);
        chk("t2_count", 32'(fifo_count), 32'd2);
        pop_check(8'h1C, 1'b0, 1'b1);
        pop_check(8'h1C, 1'b0, 1'b0);

        // Caps lock with typematic repeats
        send(8'h58, 1'b0); send(8'h58, 1'b0); send(8'h58, 1'b0);
        send(8'hF0, 1'b0); send(8'h58, 1'b0);
        chk("t3_caps_on", 32'(caps_lock), 32'd1);
        send(8'h1C, 1'b0);
        chk("t3_count", 32'(fifo_count), 32'd1);
        pop_check(8'h1C, 1'b0, 1'b1);
        send(8'h58, 1'b0); send(8'hF0, 1'b0); send(8'h58, 1'b0);
        chk("t3_caps_off", 32'(caps_lock), 32'd0);

        // Extended make/break, fake shift, pause sequence
        send(8'hE0, 1'b0); send(8'h75, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        send(8'hE0, 1'b0); send(8'h12, 1'b0);
        foreach (pause_seq[i]) send(pause_seq[i], 1'b0);
        send(8'h1C, 1'b0);
        chk("t4_count", 32'(fifo_count), 32'd2);
        chk("t4_shift", 32'(shift_held), 32'd0);
        pop_check(8'h75, 1'b1, 1'b0);
        pop_check(8'h1C, 1'b0, 1'b0);

        // Overflow on the ninth make, then drain in order
        for (int i = 0; i < 9; i++) send(8'(8'h20 + i), 1'b0);
        chk("t5_count", 32'(fifo_count), 32'd8);
        chk("t5_ovf",   32'(overflow),   32'd1);
        for (int i = 0; i < 8; i++) pop_check(8'(8'h20 + i), 1'b0, 1'b0);
        chk("t5_empty", 32'(fifo_count), 32'd0);
        chk("t5_ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-prefix with a full FIFO
        for (int i = 0; i < 8; i++) send(8'(8'h30 + i), 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0);
        do_reset();
        send(8'h75, 1'b0);
        chk("t6_count", 32'(fifo_count), 32'd1);
        chk("t6_ovf",   32'(overflow),   32'd0);
        chk("t6_code",  32'(evt_code),   32'h75);
        chk("t6_ext",   32'(evt_ext),    32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic hb;
            logic rd;
            hb = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 3) == 0);
            cycle(hb, rand_byte(), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kb_event_ctrl.md
Name: kb_event_ctrl

Overview:
- Sequences the raw PS/2 set-2 byte stream from the keyboard interface into whole key-press events for the editor core.
- Sits between keyboard (scan_code / scan_code_ready) and the ASCII translator / text buffer.
- Decodes E0/F0/E1 prefixes, tracks the shift and caps-lock state, and buffers events in a small first-word-fall-through FIFO with a valid/ready handshake.

Parameters:
FIFO_DEPTH, 8, event FIFO entries (power of 2)
ADDR_W, 3, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  asynchronous, active-high reset
scan_code  in  8  byte from keyboard interface
scan_code_ready  in  1  one-cycle strobe, scan_code valid
evt_code  out  8  make code of head event
evt_ext  out  1  head event was E0-prefixed
evt_upper  out  1  head event case flag (shift_held XOR caps_lock at capture)
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer accepts head; pop when evt_valid && evt_ready
shift_held  out  1  left (0x12) or right (0x59) shift currently down
caps_lock  out  1  caps-lock toggle state
overflow  out  1  sticky, event dropped on full FIFO
fifo_count  out  ADDR_W+1  occupancy

Behaviour:
- Reset (async): all outputs 0, FSM in IDLE, FIFO empty, shift flags, caps_lock, caps_down, skip counter and overflow cleared. Reset mid-sequence discards the partial prefix.
- Bytes are consumed only on cycles with scan_code_ready=1. Otherwise the FSM holds.
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (pause sequence).
- IDLE transitions:
  - E0 -> EXT
  - F0 -> BRK
  - E1 -> SKIP with skip counter=7
  - other code -> make handling, stay IDLE
- EXT transitions: F0 -> EXT_BRK; E0 -> stay EXT; other -> extended make handling, -> IDLE.
- BRK / EXT_BRK: any code -> break handling, -> IDLE. Repeated F0 stays in the same state.
- SKIP: each byte decrements the counter; at 0 -> IDLE. No events or state changes while in SKIP.
- Discard codes 00, FF, AA, FA, FE in any state except SKIP: no event, -> IDLE.
- Make handling, non-extended:
  - 12 / 59: set the corresponding shift flag; no event.
  - 58: if caps_down=0, toggle caps_lock and set caps_down; no event.
  - Any other code: push event {code, ext=0, upper}.
- Make handling, extended: E0 12 and E0 59 are ignored. Other codes push {code, ext=1, upper}.
- Break handling: 12 / 59 clear the corresponding shift flag; 58 clears caps_down; all others produce no event. Extended breaks never touch the shift flags.
- Typematic repeats of non-modifier makes each push a new event. Repeated 58 makes do not re-toggle caps_lock.
- upper is sampled from the flag values in the same cycle, before that byte's own update.
- Latency: push in cycle N -> evt_valid=1 and data visible in cycle N+1 (registered write, FWFT read).
- FIFO rules:
  - Push and pop in the same cycle: both performed, count unchanged.
  - Full with no pop: push dropped and overflow set until reset.
  - Full with a pop in the same cycle: push accepted.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Head outputs hold stable while evt_valid=1 and evt_ready=0.

Test Plan:
- Reset, send 1C -> next cycle evt_valid=1, evt_code=1C, evt_ext=0, evt_upper=0; evt_ready=1 -> fifo_count returns to 0.
- Send 12, 1C, F0 1C, F0 12, 1C -> exactly two events {1C, upper=1} then {1C, upper=0}; shift_held goes 1 then 0.
- Send 58, 58, 58, F0 58, 1C -> caps_lock=1 (single toggle), one event 1C with upper=1; then 58, F0 58 -> caps_lock=0.
- Send E0 75, E0 F0 75, E0 12, E1 14 77 E1 F0 14 F0 77, then 1C -> events {75, ext=1} and {1C}; the pause sequence and fake shift produce nothing.
- Hold evt_ready=0 and send 9 makes -> fifo_count=8, overflow=1, head=first code; pop all -> codes in order, ninth absent.
- Assert reset after E0 F0 with a full FIFO, release, send 75 -> event {75, ext=0}, overflow=0, count=1.
